sccb_responder: RTL

- SCCB responder (slave) for the camera configuration bus. It models the OV7670 register target, so the config writer can be checked against synthesizable logic, and it also serves as an on-FPGA bus monitor.
- Oversamples the open-drain SCL/SDA lines with the system clock, decodes 3-phase writes and 2-phase reads, and ACKs its device ID.
- Keeps a 256x8 register file and reports each completed write as a one-cycle strobe.

---
 rtl/sccb_pkg.sv | 28 ++
 rtl/sccb_line_sync.sv | 51 +++++
 rtl/sccb_responder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sccb_pkg
// Description : Shared types and constants for the SCCB responder and the
//               camera configuration writer.
// Revision    : 1.0 - initial release
// ============================================================================
package sccb_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ID       = 4'd1,
        S_ID_ACK   = 4'd2,
        S_SUB      = 4'd3,
        S_SUB_ACK  = 4'd4,
        S_DATA     = 4'd5,
        S_DATA_ACK = 4'd6,
        S_RD       = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } sccb_resp_state_t;

    localparam logic [7:0] SCCB_WR_ID    = 8'h42;
    localparam logic [7:0] SCCB_RD_ID    = 8'h43;
    localparam int         CFG_ROM_DEPTH = 72;

endpackage
`default_nettype wire

// File: rtl/sccb_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : sccb_line_sync
// Description : Synchronizes SCL/SDA into the xclk domain and derives SCL
//               edges plus START/STOP bus conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic xclk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;

    // Lines idle high, so the chain resets to 1 to avoid phantom edges.
    always_ff @(posedge xclk) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
            r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
            r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = r_scl_sync[SYNC_STAGES-1];
    assign sda_s     = r_sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~r_scl_hist;
    assign scl_fall  = ~scl_s & r_scl_hist;
    assign start_det = scl_s & r_scl_hist & r_sda_hist & ~sda_s;
    assign stop_det  = scl_s & r_scl_hist & ~r_sda_hist & sda_s;

endmodule
`default_nettype wire

// File: rtl/sccb_responder.sv
`default_nettype none
// ============================================================================
// Module      : sccb_responder
// Description : SCCB target with a 256x8 register file; decodes 3-phase
//               writes and 2-phase reads and reports committed writes.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = SCCB_WR_ID,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] REG_INIT    = 8'h00
) (
    input  logic       xclk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [7:0] txn_count,
    output logic       proto_err
);

    logic             w_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic             w_fall_slot;
    logic [7:0]       w_byte, w_rd_byte;

    sccb_resp_state_t r_state, w_state_nxt;
    logic [2:0]       r_cnt, w_cnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_drive, w_drive_nxt;
    logic             r_ack_on, w_ack_on_nxt;
    logic             r_after_data, w_after_nxt;
    logic             w_sub_latch, w_commit, w_load_tx, w_perr_set, w_midbyte_stop;

    logic [7:0]       r_regs [256];
    logic [7:0]       r_sub, r_sub_bak, r_tx;
    logic             r_wr_valid, r_busy, r_perr, r_committed;
    logic [7:0]       r_wr_addr, r_wr_data, r_txn;

    sccb_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .xclk      (xclk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .scl_s     (w_scl_s),
        .sda_s     (w_sda_s),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    assign w_fall_slot = w_scl_fall & ~w_scl_s;
    assign w_byte      = {r_shift[6:0], w_sda_s};
    assign w_rd_byte   = r_regs[r_sub];

    always_ff @(posedge xclk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd7;
            r_shift      <= 8'h00;
            r_drive      <= 1'b0;
            r_ack_on     <= 1'b0;
            r_after_data <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_drive      <= w_drive_nxt;
            r_ack_on     <= w_ack_on_nxt;
            r_after_data <= w_after_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_drive_nxt    = r_drive;
        w_ack_on_nxt   = r_ack_on;
        w_after_nxt    = r_after_data;
        w_sub_latch    = 1'b0;
        w_commit       = 1'b0;
        w_load_tx      = 1'b0;
        w_perr_set     = 1'b0;
        w_midbyte_stop = 1'b0;
        if (w_start) begin
            w_state_nxt  = S_ID;
            w_cnt_nxt    = 3'd7;
            w_drive_nxt  = 1'b0;
            w_ack_on_nxt = 1'b0;
            w_after_nxt  = 1'b0;
        end else if (w_stop) begin
            w_state_nxt    = S_IDLE;
            w_cnt_nxt      = 3'd7;
            w_drive_nxt    = 1'b0;
            w_ack_on_nxt   = 1'b0;
            w_after_nxt    = 1'b0;
            // The SCL rise that precedes a STOP is itself counted as a bit.
            w_midbyte_stop = (r_cnt < 3'd6);
            w_perr_set     = w_midbyte_stop;
        end else begin
            unique case (r_state)
                S_ID, S_SUB, S_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt - 3'd1;
                        if (r_cnt == 3'd0) begin
                            if (r_state == S_SUB) begin
                                w_state_nxt = S_SUB_ACK;
                                w_sub_latch = 1'b1;
                            end else if (r_state == S_DATA) begin
                                w_state_nxt = S_DATA_ACK;
                                w_commit    = 1'b1;
                            end else if (w_byte == DEV_ID || w_byte == (DEV_ID | 8'h01)) begin
                                w_state_nxt = S_ID_ACK;
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                S_ID_ACK, S_SUB_ACK, S_DATA_ACK: begin
                    if (w_fall_slot) begin
                        if (!r_ack_on) begin
                            w_ack_on_nxt = 1'b1;
                            w_drive_nxt  = 1'b1;
                        end else begin
                            w_ack_on_nxt = 1'b0;
                            w_drive_nxt  = 1'b0;
                            // The ID byte is still in the shifter; its LSB selects read.
                            if (r_state == S_ID_ACK) begin
                                if (r_shift[0]) begin
                                    w_state_nxt = S_RD;
                                    w_load_tx   = 1'b1;
                                    w_drive_nxt = ~w_rd_byte[7];
                                end else begin
                                    w_state_nxt = S_SUB;
                                end
                            end else if (r_state == S_SUB_ACK) begin
                                w_state_nxt = S_DATA;
                            end else begin
                                w_state_nxt = S_IGNORE;
                                w_after_nxt = 1'b1;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt - 3'd1;
                        if (r_cnt == 3'd0) begin
                            w_state_nxt = S_RD_ACK;
                        end
                    end else if (w_fall_slot) begin
                        w_drive_nxt = ~r_tx[r_cnt];
                    end
                end
                S_RD_ACK: begin
                    if (w_fall_slot) begin
                        w_drive_nxt = 1'b0;
                    end else if (w_scl_rise) begin
                        w_state_nxt = S_IGNORE;
                    end
                end
                S_IGNORE: begin
                    if (r_after_data && w_scl_rise) begin
                        w_cnt_nxt = r_cnt - 3'd1;
                        if (r_cnt == 3'd0) begin
                            w_perr_set = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge xclk) begin
        if (reset) begin
            r_sub       <= 8'h00;
            r_sub_bak   <= 8'h00;
            r_tx        <= 8'h00;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= 8'h00;
            r_wr_data   <= 8'h00;
            r_busy      <= 1'b0;
            r_perr      <= 1'b0;
            r_committed <= 1'b0;
            r_txn       <= 8'h00;
        end else begin
            r_wr_valid <= w_commit;
            if (w_commit) begin
                r_wr_addr <= r_sub;
                r_wr_data <= w_byte;
            end
            // An aborted transaction must not leave its sub-address behind.
            if (w_sub_latch) begin
                r_sub <= w_byte;
            end else if (w_midbyte_stop) begin
                r_sub <= r_sub_bak;
            end
            if (w_start && r_state == S_IDLE) begin
                r_sub_bak <= r_sub;
            end
            if (w_load_tx) begin
                r_tx <= w_rd_byte;
            end
            if (w_perr_set) begin
                r_perr <= 1'b1;
            end
            if (w_start) begin
                r_busy      <= 1'b1;
                r_committed <= 1'b0;
            end else if (w_stop) begin
                r_busy      <= 1'b0;
                r_committed <= 1'b0;
                if (r_committed) begin
                    r_txn <= r_txn + 8'd1;
                end
            end else if (w_commit) begin
                r_committed <= 1'b1;
            end
        end
    end

    always_ff @(posedge xclk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                r_regs[i] <= REG_INIT;
            end
        end else if (w_commit) begin
            r_regs[r_sub] <= w_byte;
        end
    end

    assign sda       = r_drive ? 1'b0 : 1'bz;
    assign rd_data   = r_regs[rd_addr];
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;
    assign txn_count = r_txn;
    assign proto_err = r_perr;

endmodule
`default_nettype wire
